// File: rtl/uart_cmd_parser.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_cmd_parser
//
// Parses 4-byte command frames arriving from a UART byte receiver, updates a
// 4-bit LED register, and answers through a UART byte transmitter.
//
// Frame: 0x55 (header), CMD, ARG, CHK, where a valid CHK equals CMD ^ ARG.
//   CMD 0x01 : led_flag  = ARG[3:0]
//   CMD 0x02 : led_flag |= ARG[3:0]
//   CMD 0x03 : led_flag &= ~ARG[3:0]
//   CMD 0x04 : query, led_flag unchanged
// A valid frame is answered with ACK (0x06) followed by a status byte
// {4'h0, led_flag}. A rejected frame is answered with NAK (0x15) and a
// one-cycle frame_err pulse. A stalled frame (inter-byte gap reaching
// TIMEOUT_CYC cycles) is dropped with a frame_err pulse and no reply.
//
// Parameters
//   TIMEOUT_CYC : inter-byte timeout in clk cycles, legal range 2..2^26-1.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-high reset
//   rx_Data   in   [7:0] received byte, valid while Rx_done=1
//   Rx_done   in   one-cycle strobe per received byte
//   tx_Data   out  [7:0] byte to transmit, stable while Send_Go=1
//   Send_Go   out  transmit request, held high until Tx_done
//   Tx_done   in   one-cycle strobe at end of the transmitted byte
//   led_flag  out  [3:0] LED state register
//   frame_err out  one-cycle pulse per rejected or timed-out frame
// -----------------------------------------------------------------------------
module uart_cmd_parser #(
  parameter int unsigned TIMEOUT_CYC = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_Data,
  input  logic       Rx_done,
  output logic [7:0] tx_Data,
  output logic       Send_Go,
  input  logic       Tx_done,
  output logic [3:0] led_flag,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    IDLE,
    GET_CMD,
    GET_ARG,
    GET_CHK,
    EXEC,
    SEND_ACK,
    SEND_STAT,
    SEND_NAK
  } state_t;

  localparam int unsigned CNT_W   = 26;
  localparam logic [7:0]  HDR     = 8'h55;
  localparam logic [7:0]  ACK     = 8'h06;
  localparam logic [7:0]  NAK     = 8'h15;
  // The cycle carrying the last accepted byte counts as cycle 0 of the gap,
  // and the counter reads 0 in the cycle after it. Expiring at TIMEOUT_CYC-2
  // makes the registered frame_err appear exactly TIMEOUT_CYC cycles after
  // that byte.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 2);

  state_t           state_q;
  logic [7:0]       cmd_q;
  logic [7:0]       arg_q;
  logic [7:0]       chk_q;
  logic [CNT_W-1:0] to_cnt_q;
  logic [7:0]       tx_data_q;
  logic             send_go_q;
  logic [3:0]       led_q;
  logic             frame_err_q;

  logic             in_get;
  logic             timeout;
  logic             frame_ok;

  function automatic logic [3:0] apply_cmd(input logic [7:0] cmd,
                                           input logic [3:0] led,
                                           input logic [3:0] mask);
    logic [3:0] res;
    res = led;
    case (cmd)
      8'h01:   res = mask;
      8'h02:   res = led | mask;
      8'h03:   res = led & ~mask;
      default: res = led;
    endcase
    return res;
  endfunction

  assign in_get   = (state_q == GET_CMD) || (state_q == GET_ARG) ||
                    (state_q == GET_CHK);
  // A byte arriving in the expiry cycle wins over the timeout.
  assign timeout  = in_get && !Rx_done && (to_cnt_q == TO_LAST);
  assign frame_ok = (chk_q == (cmd_q ^ arg_q)) &&
                    (cmd_q >= 8'h01) && (cmd_q <= 8'h04);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      to_cnt_q    <= '0;
      tx_data_q   <= 8'h00;
      send_go_q   <= 1'b0;
      led_q       <= 4'h0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;

      if (in_get && !Rx_done && !timeout) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end else begin
        to_cnt_q <= '0;
      end

      case (state_q)
        IDLE: begin
          if (Rx_done && (rx_Data == HDR)) begin
            state_q <= GET_CMD;
          end
        end

        GET_CMD: begin
          if (Rx_done) begin
            cmd_q   <= rx_Data;
            state_q <= GET_ARG;
          end else if (timeout) begin
            state_q     <= IDLE;
            frame_err_q <= 1'b1;
          end
        end

        GET_ARG: begin
          if (Rx_done) begin
            arg_q   <= rx_Data;
            state_q <= GET_CHK;
          end else if (timeout) begin
            state_q     <= IDLE;
            frame_err_q <= 1'b1;
          end
        end

        GET_CHK: begin
          if (Rx_done) begin
            chk_q   <= rx_Data;
            state_q <= EXEC;
          end else if (timeout) begin
            state_q     <= IDLE;
            frame_err_q <= 1'b1;
          end
        end

        EXEC: begin
          send_go_q <= 1'b1;
          if (frame_ok) begin
            led_q     <= apply_cmd(cmd_q, led_q, arg_q[3:0]);
            tx_data_q <= ACK;
            state_q   <= SEND_ACK;
          end else begin
            tx_data_q   <= NAK;
            frame_err_q <= 1'b1;
            state_q     <= SEND_NAK;
          end
        end

        SEND_ACK: begin
          // Drop Send_Go for one cycle and stage the status byte; SEND_STAT
          // re-raises the request on its first cycle.
          if (Tx_done) begin
            send_go_q <= 1'b0;
            tx_data_q <= {4'h0, led_q};
            state_q   <= SEND_STAT;
          end
        end

        SEND_STAT: begin
          if (!send_go_q) begin
            send_go_q <= 1'b1;
          end else if (Tx_done) begin
            send_go_q <= 1'b0;
            state_q   <= IDLE;
          end
        end

        SEND_NAK: begin
          if (Tx_done) begin
            send_go_q <= 1'b0;
            state_q   <= IDLE;
          end
        end

        default: begin
          state_q   <= IDLE;
          send_go_q <= 1'b0;
        end
      endcase
    end
  end

  assign tx_Data   = tx_data_q;
  assign Send_Go   = send_go_q;
  assign led_flag  = led_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
`timescale 1ns/1ps
// Testbench for uart_cmd_parser: table-driven frames plus hand-written
// sequences for timeout, stray/injected bytes and reset during a reply.
// Expected transmit bytes are queued when a frame is driven and popped when
// the DUT raises Send_Go.
module tb_uart_cmd_parser;

  localparam int TO_CYC   = 16;
  localparam int TX_DELAY = 100;

  logic       clk;
  logic       reset;
  logic [7:0] rx_Data;
  logic       Rx_done;
  logic [7:0] tx_Data;
  logic       Send_Go;
  logic       Tx_done;
  logic [3:0] led_flag;
  logic       frame_err;

  uart_cmd_parser #(.TIMEOUT_CYC(TO_CYC)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_Data   (rx_Data),
    .Rx_done   (Rx_done),
    .tx_Data   (tx_Data),
    .Send_Go   (Send_Go),
    .Tx_done   (Tx_done),
    .led_flag  (led_flag),
    .frame_err (frame_err)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       is_stat;
  } exp_t;

  typedef struct {
    logic [31:0] bytes;
    logic [3:0]  led;
    bit          ack;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   err_seen = 0;
  int   err_base = 0;
  int   cyc      = 0;
  int   fall_cyc = 0;
  logic sg_prev  = 1'b0;
  logic err_prev = 1'b0;
  logic [7:0] tx_prev = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected bytes on each Send_Go rise, checks the one-cycle
  // gap before a status byte, byte stability and frame_err width.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (Send_Go && !sg_prev) begin
        if (sb.size() == 0) begin
          check("unexpected_send", 1, 0);
        end else begin
          e = sb.pop_front();
          check("tx_byte", int'(tx_Data), int'(e.data));
          if (e.is_stat) check("stat_gap", cyc - fall_cyc, 1);
        end
      end
      if (Send_Go && sg_prev) check("tx_stable", int'(tx_Data), int'(tx_prev));
      if (frame_err && err_prev) check("frame_err_width", 2, 1);
    end
    if (!Send_Go && sg_prev) fall_cyc = cyc;
    if (frame_err && !err_prev) err_seen++;
    sg_prev  = Send_Go;
    err_prev = frame_err;
    tx_prev  = tx_Data;
    cyc++;
  end

  // Transmitter model: answers each request with Tx_done TX_DELAY cycles
  // later, abandoning the byte if reset intervenes.
  initial begin
    Tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (Send_Go && !reset) begin
        for (int k = 0; k < TX_DELAY; k++) begin
          @(posedge clk);
          if (reset) break;
        end
        if (!reset) begin
          #1 Tx_done = 1'b1;
          @(posedge clk);
          #1 Tx_done = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b);
    rx_Data = b;
    Rx_done = 1'b1;
    @(posedge clk); #1;
    Rx_done = 1'b0;
    rx_Data = 8'h00;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(sb.size() == 0 && !Send_Go && !Tx_done) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("reply_complete", (n < 1000) ? 1 : 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic push_reply(input vec_t v);
    if (v.ack) begin
      sb.push_back('{8'h06, 1'b0});
      sb.push_back('{{4'h0, v.led}, 1'b1});
    end else begin
      sb.push_back('{8'h15, 1'b0});
    end
  endtask

  // Drives one frame back to back and checks the EXEC+1 cycle (CHK + 2).
  task automatic apply_frame(input vec_t v, input bit run_to_end);
    err_base = err_seen;
    push_reply(v);
    for (int i = 3; i >= 0; i--) send_byte(v.bytes[i*8 +: 8]);
    @(posedge clk); #1;
    check("led_at_chk2", int'(led_flag), int'(v.led));
    check("send_go_at_chk2", int'(Send_Go), 1);
    check("frame_err_at_chk2", int'(frame_err), v.ack ? 0 : 1);
    if (run_to_end) begin
      wait_idle();
      check("frame_err_count", err_seen - err_base, v.ack ? 0 : 1);
    end
  endtask

  vec_t tbl [10];
  vec_t hv;

  initial begin
    int k;
    tbl[0] = '{32'h55010A0B, 4'hA, 1'b1};  // set A
    tbl[1] = '{32'h55020507, 4'hF, 1'b1};  // or 5
    tbl[2] = '{32'h55030300, 4'hC, 1'b1};  // clear 3
    tbl[3] = '{32'h55010A00, 4'hC, 1'b0};  // bad CHK
    tbl[4] = '{32'h55070007, 4'hC, 1'b0};  // bad CMD
    tbl[5] = '{32'h55040004, 4'hC, 1'b1};  // query
    tbl[6] = '{32'h5501F5F4, 4'h5, 1'b1};  // ARG[7:4] ignored
    tbl[7] = '{32'h55000000, 4'h5, 1'b0};  // CMD 0 invalid
    tbl[8] = '{32'h55555500, 4'h5, 1'b0};  // 0x55 accepted as CMD/ARG
    tbl[9] = '{32'h55025A58, 4'hF, 1'b1};  // or A

    reset   = 1'b1;
    rx_Data = 8'h00;
    Rx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_send_go", int'(Send_Go), 0);
    check("rst_tx_data", int'(tx_Data), 0);
    check("rst_led", int'(led_flag), 0);
    check("rst_frame_err", int'(frame_err), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) apply_frame(tbl[i], 1'b1);

    // Stray bytes in IDLE, then a byte injected while ACK is on the wire.
    err_base = err_seen;
    send_byte(8'h12);
    send_byte(8'h34);
    repeat (3) @(posedge clk);
    #1;
    check("stray_no_err", err_seen - err_base, 0);
    hv = '{32'h55030F0C, 4'h0, 1'b1};
    apply_frame(hv, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    send_byte(8'h55);
    send_byte(8'h01);
    wait_idle();
    check("inject_no_err", err_seen - err_base, 0);
    check("inject_led", int'(led_flag), 0);

    // Each byte arrives exactly in the would-be expiry cycle: byte wins.
    err_base = err_seen;
    hv = '{32'h55010A0B, 4'hA, 1'b1};
    push_reply(hv);
    for (int i = 3; i >= 0; i--) begin
      send_byte(hv.bytes[i*8 +: 8]);
      if (i != 0) begin
        repeat (TO_CYC - 2) @(posedge clk);
        #1;
      end
    end
    @(posedge clk); #1;
    check("edge_led", int'(led_flag), 4'hA);
    check("edge_send_go", int'(Send_Go), 1);
    wait_idle();
    check("edge_no_err", err_seen - err_base, 0);

    // Timeout after 55 01.
    err_base = err_seen;
    send_byte(8'h55);
    send_byte(8'h01);
    k = 1;
    while (!frame_err && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("timeout_latency", frame_err ? k : 0, TO_CYC);
    check("timeout_no_send", int'(Send_Go), 0);
    repeat (5) @(posedge clk);
    #1;
    check("timeout_err_count", err_seen - err_base, 1);
    check("timeout_led", int'(led_flag), 4'hA);
    hv = '{32'h55040004, 4'hA, 1'b1};
    apply_frame(hv, 1'b1);

    // Reset during SEND_ACK.
    hv = '{32'h55010706, 4'h7, 1'b1};
    apply_frame(hv, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    check("abort_send_go", int'(Send_Go), 0);
    check("abort_led", int'(led_flag), 0);
    check("abort_tx_data", int'(tx_Data), 0);
    repeat (150) @(posedge clk);
    #1;
    check("abort_quiet", int'(Send_Go), 0);
    check("abort_led_held", int'(led_flag), 0);
    hv = '{32'h55020301, 4'h3, 1'b1};
    apply_frame(hv, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 5000000, inter-byte timeout in clk cycles (100 ms at 50 MHz); legal range 2..2^26-1.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rx_Data  input  8  received byte from uart_byte_rx; valid only in the cycle Rx_done=1.
REQ-005 Rx_done  input  1  one-cycle pulse per received byte.
REQ-006 tx_Data  output  8  byte to transmit; registered; stable while Send_Go=1.
REQ-007 Send_Go  output  1  transmit request to uart_byte_tx; registered level, held until Tx_done.
REQ-008 Tx_done  input  1  one-cycle pulse marking end of the current transmitted byte.
REQ-009 led_flag  output  4  LED state register.
REQ-010 frame_err  output  1  one-cycle pulse on any rejected frame.

Function
REQ-011 Frame format SHALL be: 0x55 header, CMD, ARG, CHK, with valid CHK = CMD xor ARG.
REQ-012 States SHALL be IDLE, GET_CMD, GET_ARG, GET_CHK, EXEC, SEND_ACK, SEND_STAT, SEND_NAK.
REQ-013 IDLE: Rx_done with 0x55 -> GET_CMD; any other byte is discarded silently with no frame_err.
REQ-014 GET_CMD/GET_ARG: Rx_done latches the byte, including 0x55, and advances to the next state.
REQ-015 GET_CHK: Rx_done latches CHK -> EXEC in the next cycle.
REQ-016 EXEC lasts exactly one cycle; CHK mismatch or CMD outside 0x01..0x04 -> SEND_NAK with tx_Data=0x15 and frame_err pulse; led_flag unchanged.
REQ-017 Valid commands, applied in EXEC: 0x01 led_flag=ARG[3:0]; 0x02 led_flag|=ARG[3:0]; 0x03 led_flag&=~ARG[3:0]; 0x04 no change (query). ARG[7:4] is ignored.
REQ-018 Valid command -> SEND_ACK with tx_Data=0x06.
REQ-019 Latency: a CHK Rx_done in cycle N SHALL make the new led_flag and Send_Go=1 visible in cycle N+2.
REQ-020 SEND_x: Send_Go=1; on Tx_done, Send_Go=0 in the next cycle.
REQ-021 SEND_ACK on Tx_done -> SEND_STAT, with tx_Data={4'h0,led_flag} and Send_Go=1 again after exactly one idle cycle of Send_Go=0.
REQ-022 SEND_STAT or SEND_NAK on Tx_done -> IDLE.
REQ-023 Rx_done in EXEC or any SEND state SHALL be ignored; bytes are dropped and no state changes.
REQ-024 Tx_done outside SEND states SHALL be ignored.
REQ-025 Timeout counter: cleared on every accepted Rx_done; increments only in GET_CMD, GET_ARG and GET_CHK; held at 0 elsewhere.
REQ-026 When TIMEOUT_CYC cycles elapse with no Rx_done in a GET state -> IDLE plus frame_err pulse; no NAK is sent.
REQ-027 Rx_done in the same cycle as timeout expiry: the byte SHALL win; no timeout occurs.
REQ-028 frame_err SHALL be exactly one cycle wide per rejected frame.

Reset
REQ-029 While reset=1: state=IDLE, Send_Go=0, tx_Data=0x00, led_flag=4'h0, frame_err=0, timeout counter=0.
REQ-030 Reset asserted mid-frame or mid-send SHALL abort without any further Send_Go or led_flag change; the first frame after release SHALL parse normally.

Verification
REQ-031 Bytes 55 01 0A 0B, with Tx_done returned 100 cycles after each Send_Go -> led_flag=4'hA at CHK+2 cycles; transmitted bytes 06 then 0A; Send_Go low for exactly one cycle between them.
REQ-032 From led_flag=A: frame 55 02 05 07 -> F, response 06 0F; then frame 55 03 03 00 -> C, response 06 0C.
REQ-033 Frame 55 01 0A 00 (bad CHK) -> frame_err pulse, response 15 only, led_flag unchanged; frame 55 07 00 07 (bad CMD) -> same result.
REQ-034 With TIMEOUT_CYC=16: send 55 01, then idle -> frame_err exactly 16 cycles after the 01 byte, state IDLE, no Send_Go; a new frame 55 04 00 04 -> response 06 followed by current LED status.
REQ-035 Stray bytes 12 34 in IDLE, plus a byte injected during SEND_ACK -> no frame_err, no state change, response sequence unaffected.
REQ-036 Reset pulse during SEND_ACK -> Send_Go=0 and led_flag=0 next cycle, no STAT byte sent; the next valid frame works.
